// File: rtl/logic_pipe_unit.sv
// Registered bitwise logic unit with op select, accumulate mode, popcount and zero flags.
// Latency: one cycle from accepted beat to y/ones/zero with out_valid high.
// Backpressure: one-deep output register; in_ready drops while a result is held and out_ready is low.
module logic_pipe_unit #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [CW-1:0]    ones,
    output logic             zero,
    output logic [WIDTH-1:0] acc
);

    logic             out_valid_q;
    logic [WIDTH-1:0] y_q;
    logic [CW-1:0]    ones_q;
    logic             zero_q;
    logic [WIDTH-1:0] acc_q;

    logic [WIDTH-1:0] acc_eff;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [CW-1:0]    r_ones;
    logic             accept;

    // The slot is free when empty or being drained this cycle, independent of in_valid.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Second operand select and the bitwise result; a clear in the same beat makes acc read as 0.
    always_comb begin
        acc_eff = acc_clr ? '0 : acc_q;
        s       = acc_en ? acc_eff : b;
        r       = a;
        case (op)
            3'b000:  r = a & s;
            3'b001:  r = a | s;
            3'b010:  r = a ^ s;
            3'b011:  r = ~(a & s);
            3'b100:  r = ~(a | s);
            3'b101:  r = ~(a ^ s);
            3'b110:  r = a & ~s;
            default: r = a;
        endcase
    end

    // Population count of the result, computed before registering so the flags travel with y.
    always_comb begin
        r_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r_ones = r_ones + CW'(r[i]);
        end
    end

    // Output register: load on accept (covers simultaneous consume), otherwise drop valid on consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            ones_q      <= '0;
            zero_q      <= 1'b1;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            y_q         <= r;
            ones_q      <= r_ones;
            zero_q      <= (r == '0);
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Accumulator: an accepted accumulate beat wins over a standalone clear; stalled beats never touch it.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (accept && acc_en) begin
            acc_q <= r;
        end else if (acc_clr) begin
            acc_q <= '0;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign ones      = ones_q;
    assign zero      = zero_q;
    assign acc       = acc_q;

endmodule
